spi_burst_arbiter: RTL

Round-robin burst arbiter that shares one `axi_spi_ctrl` instance between NUM_CLIENTS byte-stream requesters. It grants one client at a time for a whole burst of LEN bytes. For each byte it pushes the client's data into the controller's TX FIFO port, pops the exchanged byte from the RX FIFO port and returns it to the client. Slave select is held asserted for the full burst. It sits between the client engines and the `axi_spi_ctrl` TX/RX FIFO ports and its `slave_select_i` input.

---
 rtl/spi_burst_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/spi_burst_arbiter.sv
// spi_burst_arbiter: round-robin arbiter that lends one SPI controller's
// TX/RX FIFO ports to one client at a time for a whole burst of bytes.
// Each byte is pushed into the TX FIFO, the exchanged byte is popped from
// the RX FIFO and returned to the client. Slave select stays asserted for
// the whole burst.
module spi_burst_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int ID_WIDTH    = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int LEN_WIDTH   = 8
) (
  input  logic                             clk_i,
  input  logic                             arst_n_i,
  input  logic                             soft_rst_i,
  input  logic [NUM_CLIENTS-1:0]           cli_req_i,
  input  logic [NUM_CLIENTS*LEN_WIDTH-1:0] cli_len_i,
  output logic [NUM_CLIENTS-1:0]           cli_gnt_o,
  input  logic [NUM_CLIENTS-1:0]           cli_tx_valid_i,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cli_tx_data_i,
  output logic [NUM_CLIENTS-1:0]           cli_tx_ready_o,
  output logic [NUM_CLIENTS-1:0]           cli_rx_valid_o,
  output logic [DATA_WIDTH-1:0]            cli_rx_data_o,
  output logic [NUM_CLIENTS-1:0]           cli_done_o,
  output logic [ID_WIDTH-1:0]              gnt_id_o,
  output logic                             slave_select_o,
  output logic                             tx_req_o,
  output logic [DATA_WIDTH-1:0]            tx_data_o,
  input  logic                             tx_ack_i,
  output logic                             rx_req_o,
  input  logic [DATA_WIDTH-1:0]            rx_data_i,
  input  logic                             rx_resp_i,
  output logic                             rx_ack_o
);

  localparam int SW = ID_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE, SELECT, PUSH, TXW, POP, RACK, RELEASE
  } state_t;

  state_t                    state;
  logic [ID_WIDTH-1:0]       rr_ptr;
  logic [LEN_WIDTH-1:0]      cnt;

  logic [2*NUM_CLIENTS-1:0]  req_dbl;
  logic [NUM_CLIENTS-1:0]    req_rot;
  logic                      pick_found;
  logic [ID_WIDTH-1:0]       pick_off;
  logic [SW-1:0]             pick_sum;
  logic [ID_WIDTH-1:0]       pick_id;
  logic [NUM_CLIENTS-1:0]    pick_oh;
  logic [LEN_WIDTH-1:0]      pick_len;
  logic [DATA_WIDTH-1:0]     gnt_tx_data;
  logic                      gnt_tx_valid;
  logic [ID_WIDTH-1:0]       rr_next;

  // Round-robin pick: rotate requests so rr_ptr sits at bit 0, take the
  // lowest set bit, then map the offset back to a client index.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so
    // no path leaves it unassigned, which would infer a latch.
    req_dbl    = {cli_req_i, cli_req_i} >> rr_ptr;
    req_rot    = req_dbl[NUM_CLIENTS-1:0];
    pick_found = 1'b0;
    pick_off   = '0;
    for (int j = NUM_CLIENTS - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        pick_found = 1'b1;
        pick_off   = ID_WIDTH'(j);
      end
    end
    pick_sum = SW'(rr_ptr) + SW'(pick_off);
    if (pick_sum >= SW'(NUM_CLIENTS)) begin
      pick_sum = pick_sum - SW'(NUM_CLIENTS);
    end
    pick_id = pick_sum[ID_WIDTH-1:0];
    pick_oh = NUM_CLIENTS'(1) << pick_id;
  end

  // Per-client muxes: burst length of the picked client, TX byte/valid of
  // the granted client (non-granted clients are masked out).
  always_comb begin
    pick_len     = '0;
    gnt_tx_data  = '0;
    gnt_tx_valid = |(cli_tx_valid_i & cli_gnt_o);
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (pick_oh[k])   pick_len    = cli_len_i[k*LEN_WIDTH +: LEN_WIDTH];
      if (cli_gnt_o[k]) gnt_tx_data = cli_tx_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign rr_next        = (gnt_id_o == ID_WIDTH'(NUM_CLIENTS - 1)) ? '0
                                                                   : gnt_id_o + ID_WIDTH'(1);
  assign cli_tx_ready_o = (state == PUSH) ? cli_gnt_o : '0;

  // Burst FSM with registered outputs; both resets clear everything.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    if (!arst_n_i) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      cnt            <= '0;
      cli_gnt_o      <= '0;
      gnt_id_o       <= '0;
      slave_select_o <= 1'b0;
      tx_req_o       <= 1'b0;
      tx_data_o      <= '0;
      rx_req_o       <= 1'b0;
      rx_ack_o       <= 1'b0;
      cli_rx_valid_o <= '0;
      cli_rx_data_o  <= '0;
      cli_done_o     <= '0;
    end else if (soft_rst_i) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      cnt            <= '0;
      cli_gnt_o      <= '0;
      gnt_id_o       <= '0;
      slave_select_o <= 1'b0;
      tx_req_o       <= 1'b0;
      tx_data_o      <= '0;
      rx_req_o       <= 1'b0;
      rx_ack_o       <= 1'b0;
      cli_rx_valid_o <= '0;
      cli_rx_data_o  <= '0;
      cli_done_o     <= '0;
    end else begin
      // Single-cycle pulses fall back to zero unless re-asserted below.
      rx_ack_o       <= 1'b0;
      cli_rx_valid_o <= '0;
      cli_done_o     <= '0;
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            cli_gnt_o <= pick_oh;
            gnt_id_o  <= pick_id;
            cnt       <= pick_len;
            state     <= (pick_len == '0) ? RELEASE : SELECT;
          end
        end
        SELECT: begin
          slave_select_o <= 1'b1;
          state          <= PUSH;
        end
        PUSH: begin
          if (gnt_tx_valid) begin
            tx_data_o <= gnt_tx_data;
            tx_req_o  <= 1'b1;
            state     <= TXW;
          end
        end
        TXW: begin
          if (tx_ack_i) begin
            tx_req_o <= 1'b0;
            rx_req_o <= 1'b1;
            state    <= POP;
          end
        end
        POP: begin
          if (rx_resp_i) begin
            cli_rx_data_o  <= rx_data_i;
            rx_req_o       <= 1'b0;
            rx_ack_o       <= 1'b1;
            cli_rx_valid_o <= cli_gnt_o;
            cnt            <= cnt - LEN_WIDTH'(1);
            state          <= RACK;
          end
        end
        RACK: begin
          state <= (cnt == '0) ? RELEASE : PUSH;
        end
        RELEASE: begin
          slave_select_o <= 1'b0;
          cli_done_o     <= cli_gnt_o;
          cli_gnt_o      <= '0;
          rr_ptr         <= rr_next;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
